// File: rtl/nn_weight_loader.sv
// nn_weight_loader: streams bias and weight words into the neuron array,
// one layer per start command, one neuron at a time (bias first, then weights).
// Optional macro NN_LOADER_LAST_CHECK_EN enables s_last framing checks and a
// sticky err flag; without it s_last is ignored and err is held at 0.
module nn_weight_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           cfg_layer,
    input  logic [CNT_WIDTH-1:0]  cfg_neurons,
    input  logic [CNT_WIDTH-1:0]  cfg_weights,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  weightValid,
    output logic [DATA_WIDTH-1:0] weightValue,
    output logic                  biasValid,
    output logic [DATA_WIDTH-1:0] biasValue,
    output logic [31:0]           config_layer_num,
    output logic [31:0]           config_neuron_num,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, BIAS, WEIGHT, FIN} state_t;

    state_t                state_q, state_d;
    logic [31:0]           layer_q, layer_d;
    logic [CNT_WIDTH-1:0]  neurons_q, neurons_d;
    logic [CNT_WIDTH-1:0]  weights_q, weights_d;
    logic [CNT_WIDTH-1:0]  neuron_cnt_q, neuron_cnt_d;
    logic [CNT_WIDTH-1:0]  weight_cnt_q, weight_cnt_d;
    logic                  weight_valid_q, weight_valid_d;
    logic [DATA_WIDTH-1:0] weight_value_q, weight_value_d;
    logic                  bias_valid_q, bias_valid_d;
    logic [DATA_WIDTH-1:0] bias_value_q, bias_value_d;
    logic [31:0]           layer_num_q, layer_num_d;
    logic [31:0]           neuron_num_q, neuron_num_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer_s;
    logic                  last_weight_s;
    logic                  last_neuron_s;

    assign s_ready       = (state_q == BIAS) || (state_q == WEIGHT);
    assign xfer_s        = s_valid && s_ready;
    assign last_weight_s = (weight_cnt_q == (weights_q - CNT_WIDTH'(1)));
    assign last_neuron_s = (neuron_cnt_q == (neurons_q - CNT_WIDTH'(1)));

    // Next-state, counter and strobe computation for the load sequence.
    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        neurons_d      = neurons_q;
        weights_d      = weights_q;
        neuron_cnt_d   = neuron_cnt_q;
        weight_cnt_d   = weight_cnt_q;
        weight_valid_d = 1'b0;
        weight_value_d = weight_value_q;
        bias_valid_d   = 1'b0;
        bias_value_d   = bias_value_q;
        layer_num_d    = layer_num_q;
        neuron_num_d   = neuron_num_q;
        done_d         = 1'b0;
        err_d          = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    layer_d      = cfg_layer;
                    neurons_d    = cfg_neurons;
                    weights_d    = cfg_weights;
                    neuron_cnt_d = '0;
                    weight_cnt_d = '0;
                    err_d        = 1'b0;
                    if ((cfg_neurons == '0) || (cfg_weights == '0)) begin
                        state_d = FIN;
                    end else begin
                        state_d = BIAS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BIAS: begin
                if (xfer_s) begin
                    bias_valid_d = 1'b1;
                    bias_value_d = s_data;
                    layer_num_d  = layer_q;
                    neuron_num_d = {{(32-CNT_WIDTH){1'b0}}, neuron_cnt_q};
                    state_d      = WEIGHT;
`ifdef NN_LOADER_LAST_CHECK_EN
                    // A bias word can never be the final word of a layer.
                    if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = err_q;
                    end
`endif
                end else begin
                    state_d = BIAS;
                end
            end
            WEIGHT: begin
                if (xfer_s) begin
                    weight_valid_d = 1'b1;
                    weight_value_d = s_data;
                    layer_num_d    = layer_q;
                    neuron_num_d   = {{(32-CNT_WIDTH){1'b0}}, neuron_cnt_q};
                    if (last_weight_s) begin
                        weight_cnt_d = '0;
                        if (last_neuron_s) begin
                            state_d = FIN;
                        end else begin
                            neuron_cnt_d = neuron_cnt_q + CNT_WIDTH'(1);
                            state_d      = BIAS;
                        end
                    end else begin
                        weight_cnt_d = weight_cnt_q + CNT_WIDTH'(1);
                        state_d      = WEIGHT;
                    end
`ifdef NN_LOADER_LAST_CHECK_EN
                    // s_last must mark exactly the last weight of the last neuron.
                    if (s_last != (last_weight_s && last_neuron_s)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = err_q;
                    end
`endif
                end else begin
                    state_d = WEIGHT;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; everything clears on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            layer_q        <= 32'd0;
            neurons_q      <= '0;
            weights_q      <= '0;
            neuron_cnt_q   <= '0;
            weight_cnt_q   <= '0;
            weight_valid_q <= 1'b0;
            weight_value_q <= '0;
            bias_valid_q   <= 1'b0;
            bias_value_q   <= '0;
            layer_num_q    <= 32'd0;
            neuron_num_q   <= 32'd0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            neurons_q      <= neurons_d;
            weights_q      <= weights_d;
            neuron_cnt_q   <= neuron_cnt_d;
            weight_cnt_q   <= weight_cnt_d;
            weight_valid_q <= weight_valid_d;
            weight_value_q <= weight_value_d;
            bias_valid_q   <= bias_valid_d;
            bias_value_q   <= bias_value_d;
            layer_num_q    <= layer_num_d;
            neuron_num_q   <= neuron_num_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign weightValid       = weight_valid_q;
    assign weightValue       = weight_value_q;
    assign biasValid         = bias_valid_q;
    assign biasValue         = bias_value_q;
    assign config_layer_num  = layer_num_q;
    assign config_neuron_num = neuron_num_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;

`ifdef NN_LOADER_LAST_CHECK_EN
    assign err = err_q;
`else
    logic unused_last_s;
    assign unused_last_s = s_last ^ err_q;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: table of full-layer loads plus
// hand-written sequences for zero counts, mid-load reset and s_last framing.
module tb_nn_weight_loader;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   cfg_layer;
    logic [CW-1:0] cfg_neurons;
    logic [CW-1:0] cfg_weights;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          weightValid;
    logic [DW-1:0] weightValue;
    logic          biasValid;
    logic [DW-1:0] biasValue;
    logic [31:0]   config_layer_num;
    logic [31:0]   config_neuron_num;
    logic          busy;
    logic          done;
    logic          err;

    nn_weight_loader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_layer(cfg_layer), .cfg_neurons(cfg_neurons), .cfg_weights(cfg_weights),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          bias;
        logic [31:0] value;
        logic [31:0] neuron;
        logic [31:0] layer;
        int          stamp;
    } strobe_t;

    typedef struct {
        int layer;
        int n;
        int w;
        bit toggle;
        bit poke;
        int exp_strobes;
    } tc_t;

    strobe_t sq[$];
    int      dq[$];
    int      xq[$];
    bit      ready_seen;
    int      n_vec = 0;
    int      n_err = 0;
    localparam logic [31:0] BASE = 32'h0000_0100;

    // Monitor: record strobes, done pulses and any s_ready activity.
    always @(negedge clk) begin
        if (weightValid || biasValid) begin
            sq.push_back('{bias: biasValid, value: (biasValid ? biasValue : weightValue),
                           neuron: config_neuron_num, layer: config_layer_num, stamp: cyc});
        end
        if (weightValid && biasValid) begin
            n_vec++;
            n_err++;
            $display("FAIL overlap: both strobes high at cycle %0d", cyc);
        end
        if (done) dq.push_back(cyc);
        if (s_ready) ready_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        sq.delete();
        dq.delete();
        xq.delete();
        ready_seen = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took start.
    task automatic do_start(input int layer, input int n, input int w);
        cfg_layer   = layer;
        cfg_neurons = CW'(n);
        cfg_weights = CW'(w);
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Offer nwords words starting at BASE; logs the cycle each strobe should appear.
    task automatic stream(input int nwords, input bit toggle, input bit poke, input int last_at);
        int  idx = 0;
        int  guard = 0;
        bit  ph = 1'b1;
        bit  xfer;
        while (idx < nwords && guard < 200) begin
            s_valid = toggle ? ph : 1'b1;
            ph      = ~ph;
            s_data  = BASE + idx;
            s_last  = (idx == last_at);
            if (poke && guard == 3) begin
                start       = 1'b1;
                cfg_layer   = 32'd9;
                cfg_neurons = CW'(1);
                cfg_weights = CW'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xfer = s_valid && s_ready;
            if (xfer) xq.push_back(cyc + 1);
            @(posedge clk); #1;
            if (xfer) idx++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        if (guard >= 200) chk("stream_timeout", idx, nwords);
    endtask

    task automatic check_load(input int n, input int w, input logic [31:0] layer,
                              input bit exp_done, input int exp_cnt);
        int k;
        chk("strobe_count", sq.size(), exp_cnt);
        for (k = 0; k < sq.size() && k < exp_cnt; k++) begin
            chk($sformatf("bias_flag[%0d]", k), {31'd0, sq[k].bias}, {31'd0, (k % (w + 1)) == 0});
            chk($sformatf("value[%0d]", k), sq[k].value, BASE + k);
            chk($sformatf("neuron[%0d]", k), sq[k].neuron, k / (w + 1));
            chk($sformatf("layer[%0d]", k), sq[k].layer, layer);
            if (k < xq.size()) chk($sformatf("stamp[%0d]", k), sq[k].stamp, xq[k]);
        end
        if (exp_done) begin
            chk("done_count", dq.size(), 1);
            if (dq.size() > 0 && sq.size() > 0)
                chk("done_cycle", dq[0], sq[sq.size()-1].stamp + 1);
        end else begin
            chk("no_done", dq.size(), 0);
        end
    endtask

    tc_t tcs[4];
    int  c0;

    initial begin
        tcs[0] = '{layer: 2, n: 3, w: 4, toggle: 1'b0, poke: 1'b0, exp_strobes: 15};
        tcs[1] = '{layer: 2, n: 3, w: 4, toggle: 1'b1, poke: 1'b0, exp_strobes: 15};
        tcs[2] = '{layer: 2, n: 3, w: 4, toggle: 1'b0, poke: 1'b1, exp_strobes: 15};
        tcs[3] = '{layer: 7, n: 2, w: 1, toggle: 1'b1, poke: 1'b0, exp_strobes: 4};

        rst = 1'b1; start = 1'b0; cfg_layer = 32'd0; cfg_neurons = '0; cfg_weights = '0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("rst_weightValid", {31'd0, weightValid}, 32'd0);
        chk("rst_biasValid", {31'd0, biasValid}, 32'd0);
        chk("rst_neuron_num", config_neuron_num, 32'd0);
        chk("rst_layer_num", config_layer_num, 32'd0);
        chk("rst_busy_ready_done_err", {28'd0, busy, s_ready, done, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            clear_logs();
            do_start(tcs[t].layer, tcs[t].n, tcs[t].w);
            stream(tcs[t].exp_strobes, tcs[t].toggle, tcs[t].poke, tcs[t].exp_strobes - 1);
            repeat (4) @(posedge clk);
            #1;
            check_load(tcs[t].n, tcs[t].w, tcs[t].layer, 1'b1, tcs[t].exp_strobes);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("hold_neuron_num", config_neuron_num, tcs[t].n - 1);
            chk("err_clear", {31'd0, err}, 32'd0);
        end

        // Zero neuron count: no handshake, done two cycles after start.
        clear_logs();
        c0 = cyc;
        do_start(4, 0, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_n_ready", {31'd0, ready_seen}, 32'd0);
        chk("zero_n_strobes", sq.size(), 0);
        chk("zero_n_done_count", dq.size(), 1);
        if (dq.size() > 0) chk("zero_n_done_cycle", dq[0], c0 + 2);

        // Zero weight count behaves the same.
        clear_logs();
        c0 = cyc;
        do_start(4, 3, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_w_strobes", sq.size(), 0);
        chk("zero_w_done_count", dq.size(), 1);

        // Reset after the 6th transfer, then a fresh 1x2 load.
        clear_logs();
        do_start(2, 3, 4);
        stream(6, 1'b0, 1'b0, -1);
        chk("pre_rst_bias", {31'd0, biasValid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {30'd0, weightValid, biasValid}, 32'd0);
        chk("rst_mid_neuron", config_neuron_num, 32'd0);
        chk("rst_mid_layer", config_layer_num, 32'd0);
        chk("rst_mid_busy_ready", {30'd0, busy, s_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        do_start(3, 1, 2);
        stream(3, 1'b0, 1'b0, 2);
        repeat (4) @(posedge clk);
        #1;
        check_load(1, 2, 3, 1'b1, 3);

`ifdef NN_LOADER_LAST_CHECK_EN
        // Early s_last on the 3rd weight aborts after its strobe.
        clear_logs();
        do_start(5, 1, 4);
        stream(4, 1'b0, 1'b0, 3);
        repeat (4) @(posedge clk);
        #1;
        check_load(1, 4, 5, 1'b0, 4);
        chk("abort_err", {31'd0, err}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        clear_logs();
        do_start(5, 1, 1);
        chk("restart_err_cleared", {31'd0, err}, 32'd0);
        stream(2, 1'b0, 1'b0, 1);
        repeat (4) @(posedge clk);
        #1;
        check_load(1, 1, 5, 1'b1, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
